// File: rtl/mult_operand_debounce.sv
// ---------------------------------------------------------------------------
// mult_operand_debounce
//
// Input front-end for the combinational multiplier on the iCESugar board.
// The raw active-low switch and button buses are inverted and synchronized
// into the clk_i domain. Each bus is then debounced as a whole, so the
// multiplier only ever sees complete, stable operands.
//
// Ports:
//   clk_i    in   1        system clock
//   reset_i  in   1        synchronous, active-high reset
//   sw_ni    in   p_width  raw switch bus, active-low, asynchronous
//   btn_ni   in   p_width  raw button bus, active-low, asynchronous
//   a_o      out  p_width  debounced active-high operand A (multiplier a_i)
//   b_o      out  p_width  debounced active-high operand B (multiplier b_i)
//   valid_o  out  1        one-cycle pulse: a_o and/or b_o changed this cycle
//
// Parameters:
//   p_width            operand width, matches the multiplier width
//   p_sync_stages      synchronizer depth per bit, 2 or more
//   p_debounce_cycles  stable cycles needed before a new value commits, 1 or more
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// mult_operand_debounce_sync
//
// Inverts a raw active-low bus and passes it through a flop chain.
//
// Ports:
//   clk_i     in   1        system clock
//   reset_i   in   1        synchronous, active-high reset
//   raw_ni    in   p_width  raw active-low bus
//   synced_o  out  p_width  active-high bus from the last flop stage
// ---------------------------------------------------------------------------
module mult_operand_debounce_sync #(
  parameter int unsigned p_width       = 4,
  parameter int unsigned p_sync_stages = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [p_width-1:0] raw_ni,
  output logic [p_width-1:0] synced_o
);

  // Stage 0 is the first flop after the pad. Reset loads 0, which is the
  // inverted idle level of an unpressed switch or button.
  logic [p_sync_stages-1:0][p_width-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[p_sync_stages-2:0], ~raw_ni};
    end
  end

  assign synced_o = stage_q[p_sync_stages-1];

endmodule

// ---------------------------------------------------------------------------
// mult_operand_debounce_fsm
//
// Debounces one synchronized bus. A change on any bit opens a settling
// window. Any further change restarts that window. The whole bus commits
// only after it has held one value for p_debounce_cycles cycles.
//
// Ports:
//   clk_i     in   1        system clock
//   reset_i   in   1        synchronous, active-high reset
//   synced_i  in   p_width  synchronized active-high bus
//   out_o     out  p_width  committed operand value
//   commit_o  out  1        high in the cycle whose rising edge loads out_o
// ---------------------------------------------------------------------------
module mult_operand_debounce_fsm #(
  parameter int unsigned p_width           = 4,
  parameter int unsigned p_debounce_cycles = 120000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [p_width-1:0] synced_i,
  output logic [p_width-1:0] out_o,
  output logic               commit_o
);

  localparam int unsigned lp_cnt_width = $clog2(p_debounce_cycles + 1);
  localparam logic [lp_cnt_width-1:0] lp_cnt_last = lp_cnt_width'(p_debounce_cycles - 1);

  typedef enum logic {
    ST_STABLE,
    ST_SETTLING
  } state_e;

  state_e                  state_q;
  logic [p_width-1:0]      out_q;
  logic [p_width-1:0]      cand_q;
  logic [lp_cnt_width-1:0] cnt_q;
  logic                    commit_d;

  // The window ends on this edge. The value loads only if it differs from
  // the current output, so a bounce back to the old value ends silently.
  assign commit_d = (state_q == ST_SETTLING) && (synced_i == cand_q) &&
                    (cnt_q == lp_cnt_last) && (cand_q != out_q);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_STABLE;
      out_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (synced_i != out_q) begin
            cand_q  <= synced_i;
            cnt_q   <= '0;
            state_q <= ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (synced_i != cand_q) begin
            // The bus is still moving, so restart the window on the new value.
            cand_q <= synced_i;
            cnt_q  <= '0;
          end else if (cnt_q == lp_cnt_last) begin
            state_q <= ST_STABLE;
            if (commit_d) begin
              out_q <= cand_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_STABLE;
        end
      endcase
    end
  end

  assign out_o    = out_q;
  assign commit_o = commit_d;

endmodule

// ---------------------------------------------------------------------------
// Top level: two independent synchronizer + debouncer lanes. The valid pulse
// is registered, so it appears together with the committed value.
// ---------------------------------------------------------------------------
module mult_operand_debounce #(
  parameter int unsigned p_width           = 4,
  parameter int unsigned p_sync_stages     = 2,
  parameter int unsigned p_debounce_cycles = 120000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [p_width-1:0] sw_ni,
  input  logic [p_width-1:0] btn_ni,
  output logic [p_width-1:0] a_o,
  output logic [p_width-1:0] b_o,
  output logic               valid_o
);

  logic [p_width-1:0] sw_synced;
  logic [p_width-1:0] btn_synced;
  logic               commit_a;
  logic               commit_b;
  logic               valid_q;

  mult_operand_debounce_sync #(
    .p_width       (p_width),
    .p_sync_stages (p_sync_stages)
  ) u_sync_a (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .raw_ni   (sw_ni),
    .synced_o (sw_synced)
  );

  mult_operand_debounce_sync #(
    .p_width       (p_width),
    .p_sync_stages (p_sync_stages)
  ) u_sync_b (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .raw_ni   (btn_ni),
    .synced_o (btn_synced)
  );

  mult_operand_debounce_fsm #(
    .p_width           (p_width),
    .p_debounce_cycles (p_debounce_cycles)
  ) u_fsm_a (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .synced_i (sw_synced),
    .out_o    (a_o),
    .commit_o (commit_a)
  );

  mult_operand_debounce_fsm #(
    .p_width           (p_width),
    .p_debounce_cycles (p_debounce_cycles)
  ) u_fsm_b (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .synced_i (btn_synced),
    .out_o    (b_o),
    .commit_o (commit_b)
  );

  // Commits on A and B in the same cycle merge into a single pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= commit_a | commit_b;
    end
  end

  assign valid_o = valid_q;

endmodule

// File: doc/mult_operand_debounce.md
Name: mult_operand_debounce

Overview:
- Input front-end stage that feeds the combinational multiplier on the iCESugar board.
- Takes raw active-low switch and button buses and synchronizes them into the clock domain.
- Debounces each bus, inverts it to active-high and presents stable operands a_o/b_o to the multiplier's a_i/b_i.
- valid_o pulses whenever either operand takes a new committed value, so downstream logic can register the product.

Parameters:
- p_width, 4, operand width in bits; equals multiplier p_width.
- p_sync_stages, 2, synchronizer flop depth per input bit; legal values are 2 or more.
- p_debounce_cycles, 120000, consecutive stable cycles required before a new value commits (10 ms at 12 MHz); legal values are 1 or more.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous, active-high reset.
- sw_ni  input  p_width  raw switch bus, active-low, asynchronous to clk_i.
- btn_ni  input  p_width  raw button bus, active-low, asynchronous to clk_i.
- a_o  output  p_width  debounced, active-high operand A; connects to multiplier a_i.
- b_o  output  p_width  debounced, active-high operand B; connects to multiplier b_i.
- valid_o  output  1  single-cycle pulse marking that a_o and/or b_o changed this cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk_i.
  - reset_i is synchronous and active-high; it is sampled only on the rising edge of clk_i.
- Reset values:
  - All synchronizer flops are 0 (the inverted idle level).
  - a_o = 0, b_o = 0, valid_o = 0.
  - Both FSMs go to STABLE and both counters go to 0.
  - Reset asserted mid-settle abandons the candidate and produces no valid_o pulse.
- Input path:
  - Each raw bit is inverted, then passes through p_sync_stages flops.
  - The last stage is called synced; it is sampled as a whole bus, not bit by bit.
- Per-bus FSM (two identical instances, one for A and one for B):
  - Registers: out (drives a_o/b_o), cand (candidate value), cnt (width $clog2(p_debounce_cycles+1)).
  - STABLE, when synced != out: cand <= synced, cnt <= 0, go to SETTLING.
  - SETTLING, when synced != cand: cand <= synced, cnt <= 0, stay in SETTLING (the bounce restarts the window).
  - SETTLING, when synced == cand and cnt == p_debounce_cycles-1: go to STABLE. If cand != out, also out <= cand and a commit flag is raised.
  - SETTLING, when synced == cand and cnt < p_debounce_cycles-1: cnt <= cnt+1.
  - If the bus bounces back to the old out value before committing, it returns to STABLE silently: out is unchanged and no commit is flagged.
- Latency:
  - A raw change that is set up before edge 1 and held stable updates the output on edge p_sync_stages + p_debounce_cycles + 1.
  - With p_sync_stages=2, that is edge p_debounce_cycles+3.
- valid_o:
  - Registered; equal to commit_a OR commit_b.
  - Asserts in the same cycle the new a_o/b_o values first appear.
  - Simultaneous commits on A and B produce exactly one pulse.
  - Never high for two consecutive cycles from a single commit.
- Data handling:
  - No arithmetic on the data path.
  - a_o/b_o hold their value indefinitely between commits.
  - The multi-bit bus commits atomically: no partial-bit updates ever reach the multiplier.

Test Plan (p_width=4, p_sync_stages=2, p_debounce_cycles=4):
- Reset check: hold reset_i for 3 cycles with sw_ni=4'b0000 -> a_o=0, b_o=0, valid_o=0 during reset; after release, a_o=4'hF on edge 7 with a single valid_o pulse.
- Clean change: with sw_ni=4'hF, set sw_ni=4'hC (A=3) before edge 1 and hold -> a_o=4'h3 and valid_o=1 exactly at edge 7; valid_o=0 at edge 8; b_o unchanged.
- Bounce restarts the window: toggle sw_ni between 4'hC and 4'hF every 2 cycles for 10 cycles, then hold 4'hC -> no commit during the toggling; a_o=3 exactly 7 edges after the last toggle; exactly one valid_o pulse.
- Glitch rejection: pulse btn_ni=4'h7 for 2 cycles, then return to 4'hF -> b_o stays 0 and valid_o is never asserted.
- Simultaneous commits: change sw_ni->4'h8 and btn_ni->4'hE on the same cycle -> a_o=7 and b_o=1 on the same edge, with one single-cycle valid_o.
- Reset mid-settle: start sw_ni->4'h0, assert reset_i at cnt=2 for 1 cycle while holding the input -> a_o=0 after reset, no valid_o; then a_o=4'hF 7 edges after reset release.
